// File: rtl/axis_fifo_pkg.sv
// Shared constants and helpers for the AXI4-Stream FIFO: sideband defaults,
// pointer width and the bit layout of a stored beat.
package axis_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DEPTH       = 16;
  localparam bit DEF_LAST_ENABLE = 1'b1;
  localparam bit DEF_ID_ENABLE   = 1'b0;
  localparam bit DEF_DEST_ENABLE = 1'b0;
  localparam bit DEF_USER_ENABLE = 1'b1;
  localparam int DEF_ID_WIDTH    = 8;
  localparam int DEF_DEST_WIDTH  = 8;
  localparam int DEF_USER_WIDTH  = 1;

  // Field order of a stored beat, most significant first: {tdata,tkeep,tlast,tid,tdest,tuser}
  typedef enum logic [2:0] {
    FLD_TDATA,
    FLD_TKEEP,
    FLD_TLAST,
    FLD_TID,
    FLD_TDEST,
    FLD_TUSER
  } beat_field_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int fld_w(input bit en, input int w);
    return en ? w : 0;
  endfunction

  // Widths passed in are already gated by their enables; later fields sit below.
  function automatic int fld_lsb(input beat_field_e f, input int kw, input int lw,
                                 input int iw, input int dw, input int uw);
    int lsb;
    lsb = 0;
    if (f < FLD_TUSER) lsb += uw;
    if (f < FLD_TDEST) lsb += dw;
    if (f < FLD_TID)   lsb += iw;
    if (f < FLD_TLAST) lsb += lw;
    if (f < FLD_TKEEP) lsb += kw;
    return lsb;
  endfunction

endpackage

// File: rtl/axis_fifo_if.sv
// AXI4-Stream bundle shared by both FIFO ports; sidebands are always present
// in the bundle, the FIFO decides which ones it carries.
interface ifc_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, registered read with enable.
// The read register doubles as the FIFO head slot, so it is reset to zero.
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_fifo.sv
// First-word-fall-through AXI4-Stream FIFO, single clock, registered head slot.
// Optional `AXIS_FIFO_COUNT_EN adds a count output of beats held (head included).
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit LAST_ENABLE = DEF_LAST_ENABLE,
  parameter bit ID_ENABLE   = DEF_ID_ENABLE,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter bit DEST_ENABLE = DEF_DEST_ENABLE,
  parameter int DEST_WIDTH  = DEF_DEST_WIDTH,
  parameter bit USER_ENABLE = DEF_USER_ENABLE,
  parameter int USER_WIDTH  = DEF_USER_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  ifc_axis.slave    s_axis_ifc,
  ifc_axis.master   m_axis_ifc
`ifdef AXIS_FIFO_COUNT_EN
  ,
  output logic [ptr_w(DEPTH)-1:0] count
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  localparam int KW = fld_w(KEEP_ENABLE, KEEP_WIDTH);
  localparam int LW = fld_w(LAST_ENABLE, 1);
  localparam int IW = fld_w(ID_ENABLE, ID_WIDTH);
  localparam int DW = fld_w(DEST_ENABLE, DEST_WIDTH);
  localparam int UW = fld_w(USER_ENABLE, USER_WIDTH);
  localparam int WIDTH = DATA_WIDTH + KW + LW + IW + DW + UW;

  localparam int KEEP_LSB = fld_lsb(FLD_TKEEP, KW, LW, IW, DW, UW);
  localparam int LAST_LSB = fld_lsb(FLD_TLAST, KW, LW, IW, DW, UW);
  localparam int ID_LSB   = fld_lsb(FLD_TID,   KW, LW, IW, DW, UW);
  localparam int DEST_LSB = fld_lsb(FLD_TDEST, KW, LW, IW, DW, UW);
  localparam int USER_LSB = fld_lsb(FLD_TUSER, KW, LW, IW, DW, UW);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic             s_ready;
  logic             head_valid;
  logic             do_write, do_read, fetch, full_nxt;
  logic [WIDTH-1:0] wr_word, rd_word;

  assign do_write   = s_axis_ifc.tvalid & s_ready;
  assign do_read    = head_valid & m_axis_ifc.tready;
  assign wr_ptr_nxt = wr_ptr + PW'(do_write);
  assign rd_ptr_nxt = rd_ptr + PW'(do_read);

  // rd_ptr marks the beat in the head slot, so the slot stays counted until it
  // is read; a beat written this cycle is not yet visible to the fetch (no bypass).
  assign fetch    = (~head_valid | do_read) & (wr_ptr != rd_ptr_nxt);
  assign full_nxt = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      s_ready    <= 1'b0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      s_ready    <= ~full_nxt;
      head_valid <= fetch | (head_valid & ~do_read);
    end
  end

  assign s_axis_ifc.tready = s_ready;
  assign m_axis_ifc.tvalid = head_valid;

`ifdef AXIS_FIFO_COUNT_EN
  assign count = wr_ptr - rd_ptr;
`endif

  axis_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (do_write),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_word),
    .rd_en   (fetch),
    .rd_addr (rd_ptr_nxt[AW-1:0]),
    .rd_data (rd_word)
  );

  assign wr_word[WIDTH-1 -: DATA_WIDTH] = s_axis_ifc.tdata;
  assign m_axis_ifc.tdata               = rd_word[WIDTH-1 -: DATA_WIDTH];

  // Disabled sidebands are not stored and drive their fixed defaults.
  generate
    if (KEEP_ENABLE) begin : g_keep
      assign wr_word[KEEP_LSB +: KEEP_WIDTH] = s_axis_ifc.tkeep;
      assign m_axis_ifc.tkeep = rd_word[KEEP_LSB +: KEEP_WIDTH];
    end else begin : g_no_keep
      assign m_axis_ifc.tkeep = '1;
    end

    if (LAST_ENABLE) begin : g_last
      assign wr_word[LAST_LSB] = s_axis_ifc.tlast;
      assign m_axis_ifc.tlast  = rd_word[LAST_LSB];
    end else begin : g_no_last
      assign m_axis_ifc.tlast = 1'b1;
    end

    if (ID_ENABLE) begin : g_id
      assign wr_word[ID_LSB +: ID_WIDTH] = s_axis_ifc.tid;
      assign m_axis_ifc.tid = rd_word[ID_LSB +: ID_WIDTH];
    end else begin : g_no_id
      assign m_axis_ifc.tid = '0;
    end

    if (DEST_ENABLE) begin : g_dest
      assign wr_word[DEST_LSB +: DEST_WIDTH] = s_axis_ifc.tdest;
      assign m_axis_ifc.tdest = rd_word[DEST_LSB +: DEST_WIDTH];
    end else begin : g_no_dest
      assign m_axis_ifc.tdest = '0;
    end

    if (USER_ENABLE) begin : g_user
      assign wr_word[USER_LSB +: USER_WIDTH] = s_axis_ifc.tuser;
      assign m_axis_ifc.tuser = rd_word[USER_LSB +: USER_WIDTH];
    end else begin : g_no_user
      assign m_axis_ifc.tuser = '0;
    end
  endgenerate

  // Sideband inputs of disabled fields have no load.
  logic unused_sb;
  assign unused_sb = ^{s_axis_ifc.tkeep, s_axis_ifc.tlast, s_axis_ifc.tid,
                       s_axis_ifc.tdest, s_axis_ifc.tuser};

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo: a wide LAST-only instance and a narrow
// instance carrying every sideband, each checked by a queue scoreboard.
module tb_axis_fifo;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  ifc_axis #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) a_s ();
  ifc_axis #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) a_m ();
  ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(4), .DEST_WIDTH(3), .USER_WIDTH(2)) b_s ();
  ifc_axis #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .ID_WIDTH(4), .DEST_WIDTH(3), .USER_WIDTH(2)) b_m ();

`ifdef AXIS_FIFO_COUNT_EN
  logic [4:0] a_count, b_count;
`endif

  axis_fifo #(
    .DATA_WIDTH(128), .DEPTH(16), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(16),
    .LAST_ENABLE(1'b1), .ID_ENABLE(1'b0), .DEST_ENABLE(1'b0), .USER_ENABLE(1'b0)
  ) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .s_axis_ifc (a_s),
    .m_axis_ifc (a_m)
`ifdef AXIS_FIFO_COUNT_EN
    , .count    (a_count)
`endif
  );

  axis_fifo #(
    .DATA_WIDTH(32), .DEPTH(16), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(4),
    .LAST_ENABLE(1'b1), .ID_ENABLE(1'b1), .ID_WIDTH(4), .DEST_ENABLE(1'b1), .DEST_WIDTH(3),
    .USER_ENABLE(1'b1), .USER_WIDTH(2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .s_axis_ifc (b_s),
    .m_axis_ifc (b_m)
`ifdef AXIS_FIFO_COUNT_EN
    , .count    (b_count)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: 128-bit, LAST only, always ready ----------------
  logic [128:0] qa[$];
  logic         a_run = 1'b0;
  logic         a_done = 1'b0;
  int           a_out = 0;

  always @(negedge clk) begin
    if (a_run) begin
      if (a_m.tvalid && a_m.tready) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_extra_beat actual=%0h required=none", a_m.tdata);
        end else begin
          logic [128:0] e;
          e = qa.pop_front();
          chk("a_data", a_m.tdata, e[127:0]);
          chk("a_last", a_m.tlast, e[128]);
          chk("a_keep_default", a_m.tkeep, 16'hFFFF);
          chk("a_id_default", a_m.tid, 0);
          chk("a_dest_default", a_m.tdest, 0);
          chk("a_user_default", a_m.tuser, 0);
        end
        a_out++;
      end
      if (a_s.tvalid && a_s.tready) qa.push_back({a_s.tlast, a_s.tdata});
    end
  end

  initial begin
    int idx, cyc;
    logic acc;
    rst_a = 1'b0;
    a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tlast = 1'b0;
    a_s.tkeep = '0; a_s.tid = '0; a_s.tdest = '0; a_s.tuser = '0;
    a_m.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_a = 1'b1;
    @(posedge clk); #1;
    a_run = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 2048 && cyc < 20000) begin
      if (!a_s.tvalid && ($urandom_range(1) == 1)) begin
        a_s.tvalid = 1'b1;
        a_s.tdata  = {$urandom, $urandom, $urandom, $urandom};
        a_s.tlast  = (idx == 2047);
        a_s.tkeep  = 16'($urandom);
        a_s.tid    = 8'($urandom);
        a_s.tdest  = 8'($urandom);
        a_s.tuser  = 1'($urandom);
      end
      @(negedge clk);
      acc = a_s.tvalid && a_s.tready;
      @(posedge clk); #1;
      if (acc) begin a_s.tvalid = 1'b0; idx++; end
      cyc++;
    end
    a_s.tvalid = 1'b0;
    for (int i = 0; i < 100 && a_out < 2048; i++) @(posedge clk);
    chk("a_beats_out", a_out, 2048);
    a_done = 1'b1;
  end

  // ---------------- instance B: all sidebands, random handshakes ----------------
  logic [45:0] qb[$];
  logic [45:0] b_in_w, b_out_w, held_word;
  logic        b_run = 1'b0;
  logic        last_push = 1'b0;
  logic        held = 1'b0;
  int          b_acc = 0;
  int          b_rd = 0;
  int          b_occ;

  assign b_in_w  = {b_s.tdata, b_s.tkeep, b_s.tlast, b_s.tid, b_s.tdest, b_s.tuser};
  assign b_out_w = {b_m.tdata, b_m.tkeep, b_m.tlast, b_m.tid, b_m.tdest, b_m.tuser};

  // Beats held = accepted minus read; the head shows only beats accepted before the last edge.
  always @(negedge clk) begin
    if (b_run) begin
      b_occ = qb.size();
      chk("b_s_tready", b_s.tready, b_occ < 16);
      chk("b_m_tvalid", b_m.tvalid, (b_occ - int'(last_push)) > 0);
`ifdef AXIS_FIFO_COUNT_EN
      chk("b_count", b_count, b_occ);
      chk("b_count_max", b_count <= 16, 1'b1);
`endif
      if (held) chk("b_stall_stable", b_out_w, held_word);
      held = b_m.tvalid && !b_m.tready;
      held_word = b_out_w;
      if (b_m.tvalid && b_m.tready) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_extra_beat actual=%0h required=none", b_out_w);
        end else begin
          chk("b_beat", b_out_w, qb.pop_front());
        end
        b_rd++;
      end
      last_push = 1'b0;
      if (b_s.tvalid && b_s.tready) begin
        qb.push_back(b_in_w);
        last_push = 1'b1;
        b_acc++;
      end
    end
  end

  task automatic rand_b_fields();
    b_s.tdata = $urandom;
    b_s.tkeep = 4'($urandom);
    b_s.tlast = 1'($urandom);
    b_s.tid   = 4'($urandom);
    b_s.tdest = 3'($urandom);
    b_s.tuser = 2'($urandom);
  endtask

  task automatic drive_b(input int n, input int pv, input int pr, input int max_cyc);
    int sent, cyc;
    logic acc;
    sent = 0; cyc = 0;
    while (sent < n && cyc < max_cyc) begin
      if (!b_s.tvalid && ($urandom_range(99) < pv)) begin
        b_s.tvalid = 1'b1;
        rand_b_fields();
      end
      b_m.tready = ($urandom_range(99) < pr);
      @(negedge clk);
      acc = b_s.tvalid && b_s.tready;
      @(posedge clk); #1;
      if (acc) begin b_s.tvalid = 1'b0; sent++; end
      cyc++;
    end
    b_s.tvalid = 1'b0;
    chk("b_drive_sent", sent, n);
  endtask

  task automatic drain_b();
    b_s.tvalid = 1'b0;
    b_m.tready = 1'b1;
    for (int i = 0; i < 200 && (qb.size() != 0 || b_m.tvalid); i++) begin
      @(posedge clk); #1;
    end
    chk("b_drain_empty", qb.size(), 0);
  endtask

  initial begin
    int n, acc0, rd0;
    logic acc;
    rst_b = 1'b0;
    b_s.tvalid = 1'b0;
    rand_b_fields();
    b_m.tready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_m_tvalid", b_m.tvalid, 0);
    chk("rst_s_tready", b_s.tready, 0);
    chk("rst_m_tdata", b_m.tdata, 0);
    chk("rst_m_tuser", b_m.tuser, 0);
`ifdef AXIS_FIFO_COUNT_EN
    chk("rst_count", b_count, 0);
`endif
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    chk("rel_s_tready", b_s.tready, 1);
    b_run = 1'b1;

    // single beat into an empty FIFO
    b_m.tready = 1'b1;
    b_s.tvalid = 1'b1;
    rand_b_fields();
    b_s.tdata = 32'hA5;
    b_s.tlast = 1'b1;
    @(negedge clk);
    chk("t3_accept_ready", b_s.tready, 1);
    @(posedge clk); #1;
    b_s.tvalid = 1'b0;
    @(negedge clk);
    chk("t3_no_bypass", b_m.tvalid, 0);
    @(negedge clk);
    chk("t3_valid", b_m.tvalid, 1);
    chk("t3_data", b_m.tdata, 32'hA5);
    chk("t3_last", b_m.tlast, 1);
    @(posedge clk); #1;

    // fill with downstream stalled: 20 offered, 16 taken
    b_m.tready = 1'b0;
    acc0 = b_acc;
    n = 0;
    b_s.tvalid = 1'b1;
    rand_b_fields();
    b_s.tdata = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = b_s.tvalid && b_s.tready;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        rand_b_fields();
        b_s.tdata = n;
      end
      if (n == 16) chk("t2_full_ready_low", b_s.tready, 0);
    end
    b_s.tvalid = 1'b0;
    chk("t2_accepted", b_acc - acc0, 16);
    b_m.tready = 1'b1;
    rd0 = b_rd;
    @(posedge clk); #1;
    chk("t2_ready_after_read", b_s.tready, 1);
    repeat (15) @(negedge clk);
    #1;
    chk("t2_reads_back_to_back", b_rd - rd0, 16);
    drain_b();

    // long random run, random back-pressure, random sidebands
    drive_b(10000, 70, 70, 60000);
    drain_b();

    // reset with 7 beats stored
    drive_b(7, 100, 0, 100);
    @(posedge clk); #3;
    rst_b = 1'b0;
    b_run = 1'b0;
    #1;
    chk("t5_rst_m_tvalid", b_m.tvalid, 0);
    chk("t5_rst_s_tready", b_s.tready, 0);
`ifdef AXIS_FIFO_COUNT_EN
    chk("t5_rst_count", b_count, 0);
`endif
    qb.delete();
    last_push = 1'b0;
    held = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    chk("t5_rel_s_tready", b_s.tready, 1);
    chk("t5_rel_m_tvalid", b_m.tvalid, 0);
    b_run = 1'b1;
    drive_b(40, 70, 70, 2000);
    drain_b();

    for (int i = 0; i < 50000 && !a_done; i++) @(posedge clk);
    chk("a_finished", a_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
